// File: rtl/vertex_pkg.sv
// Shared definitions for the vertex arbiter: word layout, tile-id
// fields and arbiter state encodings.
package vertex_pkg;

    localparam int VW      = 122;
    localparam int CMD_BIT = 121;
    localparam int CMD_HI  = 121;
    localparam int CMD_LO  = 114;
    localparam int VTX_W   = 38;

    localparam logic [7:0] CMD_TILE = 8'h80;

    typedef struct packed {
        logic [2:0] id_y;
        logic [3:0] id_x;
    } tile_id_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    function automatic logic is_tile_cmd(input logic [VW-1:0] w);
        return w[CMD_BIT];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr,
// wrapping around.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] index
);

    int j;

    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                index = PW'(j);
            end
        end
    end

endmodule

// File: rtl/vertex_arb.sv
// Packet-locked round-robin arbiter feeding one registered word per
// cycle into the vertex FIFO.
module vertex_arb #(
    parameter int NUM_REQ = 4,
    parameter int VW      = vertex_pkg::VW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*VW-1:0]      req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [VW-1:0]              vertices_wrdata,
    output logic                       vertices_push,
    input  logic                       vertices_full,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic [15:0]                pkt_count
);

    import vertex_pkg::*;

    localparam int PW = $clog2(NUM_REQ);

    logic [0:0]    state;
    logic [PW-1:0] rr_ptr;
    logic          out_valid;
    logic [VW-1:0] out_data;

    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic          accept;
    logic          ack_en;
    logic [PW-1:0] ack_idx;
    logic [VW-1:0] sel_word;
    logic          sel_last;
    logic [PW-1:0] next_ptr;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign vertices_wrdata = out_data;
    assign vertices_push   = rst & out_valid & ~vertices_full;
    assign accept          = ~out_valid | vertices_push;

    always_comb begin
        ack_en  = 1'b0;
        ack_idx = owner;
        unique case (state)
            ST_IDLE: begin
                ack_idx = pick_idx;
                ack_en  = pick_valid & accept;
            end
            ST_LOCK: begin
                ack_idx = owner;
                ack_en  = req[owner] & accept;
            end
            default: begin
                ack_en  = 1'b0;
            end
        endcase
        ack_en = ack_en & rst;
    end

    always_comb begin
        sel_word = req_data[int'(ack_idx)*VW +: VW];
        sel_last = req_last[ack_idx];
        req_ack  = '0;
        if (ack_en) begin
            req_ack[ack_idx] = 1'b1;
        end
    end

    assign next_ptr = (int'(ack_idx) == NUM_REQ - 1) ? '0 : ack_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (ack_en) begin
            out_valid <= 1'b1;
            out_data  <= sel_word;
        end else if (vertices_push) begin
            out_valid <= 1'b0;
        end
    end

    // Grant lock is released only by an accepted last word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            pkt_count <= '0;
        end else if (ack_en) begin
            owner <= ack_idx;
            if (sel_last) begin
                state     <= ST_IDLE;
                rr_ptr    <= next_ptr;
                pkt_count <= pkt_count + 16'd1;
            end else begin
                state <= ST_LOCK;
            end
        end
    end

endmodule

// File: tb/tb_vertex_arb.sv
// Randomized scoreboard bench for vertex_arb against a packet-level
// reference model.
module tb_vertex_arb;

    import vertex_pkg::*;

    localparam int N   = 4;
    localparam int W   = 122;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ack;
    logic [W-1:0]   wrdata;
    logic           push;
    logic           full = 1'b0;
    logic [1:0]     owner;
    logic [15:0]    pkt_count;

    int total  = 0;
    int passed = 0;

    logic [W-1:0] wq[N][$];
    bit           lq[N][$];
    logic [W-1:0] sb[$];

    int gap_cnt[N];
    int full_cnt  = 0;
    int full_pct  = 0;
    int gap_pct   = 0;
    bit rst_pulse = 1'b1;

    bit m_locked = 1'b0;
    bit m_valid  = 1'b0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_pkts   = 0;

    vertex_arb #(
        .NUM_REQ (N),
        .VW      (W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ack         (req_ack),
        .vertices_wrdata (wrdata),
        .vertices_push   (push),
        .vertices_full   (full),
        .owner           (owner),
        .pkt_count       (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [127:0] got, logic [127:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic add_pkt(int n, int len);
        logic [63:0]  ra, rb, rc;
        logic [7:0]   cmd;
        tile_id_t     tid;
        logic [W-1:0] w;
        for (int i = 0; i < len; i++) begin
            ra  = {$urandom(), $urandom()};
            rb  = {$urandom(), $urandom()};
            rc  = {$urandom(), $urandom()};
            cmd = 8'h00;
            if (i == 0) begin
                cmd = CMD_TILE;
                tid = tile_id_t'($urandom_range(127));
                ra  = {57'd0, tid};
            end
            w = {cmd, ra[37:0], rb[37:0], rc[37:0]};
            wq[n].push_back(w);
            lq[n].push_back(i == len - 1);
        end
    endtask

    task automatic drive();
        bit g;
        rst = !rst_pulse;
        for (int n = 0; n < N; n++) begin
            g = (gap_cnt[n] > 0) ||
                (gap_pct > 0 && $urandom_range(99) < gap_pct);
            if (gap_cnt[n] > 0) gap_cnt[n]--;
            if (wq[n].size() > 0 && !g) begin
                req[n] = 1'b1;
                req_data[n*W +: W] = wq[n][0];
                req_last[n] = lq[n][0];
            end else begin
                req[n] = 1'b0;
                req_last[n] = 1'b0;
            end
        end
        full = (full_cnt > 0) ||
               (full_pct > 0 && $urandom_range(99) < full_pct);
        if (full_cnt > 0) full_cnt--;
    endtask

    task automatic model_step();
        logic [N-1:0] want_ack;
        int  pick;
        int  j;
        bit  m_push;
        bit  l;
        want_ack = '0;
        pick     = -1;
        m_push   = m_valid && !full;
        if (rst) begin
            if (!m_locked) begin
                for (int i = 0; i < N; i++) begin
                    j = (m_ptr + i) % N;
                    if (pick < 0 && req[j]) pick = j;
                end
            end else if (req[m_owner]) begin
                pick = m_owner;
            end
            if (m_valid && !m_push) pick = -1;
            if (pick >= 0) want_ack[pick] = 1'b1;
        end
        chk("req_ack", 128'(req_ack), 128'(want_ack));
        chk("push", 128'(push), 128'(rst && m_push));
        chk("owner", 128'(owner), 128'(m_owner));
        chk("pkt_count", 128'(pkt_count), 128'(16'(m_pkts)));
        if (!rst) begin
            m_locked = 1'b0;
            m_valid  = 1'b0;
            m_owner  = 0;
            m_ptr    = 0;
            m_pkts   = 0;
            sb.delete();
            for (int n = 0; n < N; n++) begin
                wq[n].delete();
                lq[n].delete();
            end
        end else begin
            if (m_push) m_valid = 1'b0;
            if (pick >= 0) begin
                sb.push_back(wq[pick].pop_front());
                l = lq[pick].pop_front();
                m_valid = 1'b1;
                m_owner = pick;
                if (l) begin
                    m_locked = 1'b0;
                    m_ptr    = (pick + 1) % N;
                    m_pkts   = (m_pkts + 1) % 65536;
                end else begin
                    m_locked = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        model_step();
    endtask

    function automatic bit idle();
        bit e;
        e = !m_valid && sb.size() == 0;
        for (int n = 0; n < N; n++) e = e && wq[n].size() == 0;
        return e;
    endfunction

    task automatic run(string name, int maxc);
        bit done;
        done = 1'b0;
        for (int c = 0; c < maxc && !done; c++) begin
            cycle();
            done = idle();
        end
        chk(name, 128'(done), 128'(1'b1));
    endtask

    task automatic pulse_reset();
        rst_pulse = 1'b1;
        cycle();
        rst_pulse = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && push === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL wrdata: unexpected push of %h, none expected", wrdata);
            end else begin
                chk("wrdata", 128'(wrdata), 128'(sb.pop_front()));
            end
        end
    end

    initial begin
        for (int n = 0; n < N; n++) gap_cnt[n] = 0;
        cycle();
        cycle();
        rst_pulse = 1'b0;

        add_pkt(0, 4);
        run("single_pkt", 20);

        pulse_reset();
        add_pkt(0, 3);
        add_pkt(2, 3);
        run("contention", 30);

        add_pkt(1, 6);
        cycle();
        cycle();
        full_cnt = 5;
        run("backpressure", 40);

        for (int k = 0; k < 3; k++)
            for (int n = 0; n < N; n++) add_pkt(n, 1);
        run("fairness", 40);

        add_pkt(3, 5);
        cycle();
        cycle();
        add_pkt(1, 2);
        gap_cnt[3] = 3;
        run("owner_stall", 40);

        full_pct = 30;
        gap_pct  = 15;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < N; n++)
                if (wq[n].size() == 0 && $urandom_range(3) == 0)
                    add_pkt(n, int'($urandom_range(5, 1)));
            cycle();
        end
        full_pct = 0;
        gap_pct  = 0;
        run("random_drain", 200);

        add_pkt(2, 4);
        add_pkt(0, 2);
        cycle();
        cycle();
        pulse_reset();
        add_pkt(1, 2);
        add_pkt(0, 2);
        run("reset_mid_pkt", 30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
